// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and parameter-derived index helpers for the window controller
package conv_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_COMPUTE = 3'd2,
    S_SKIP    = 3'd3,
    S_DONE    = 3'd4
  } state_t;
  function automatic int first_idx(input int k);
    return k - 1;
  endfunction
  function automatic int skip_end(input int k);
    return k - 2;
  endfunction
  function automatic int last_idx(input int n);
    return n - 1;
  endfunction
  function automatic bit stride_ok(input int s);
    return s == 1 || s == 2;
  endfunction
endpackage

// File: rtl/conv_raster_cnt.sv
// conv_raster_cnt: column/row raster counters with wrap, clear and enable
module conv_raster_cnt
  import conv_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_C = CW'(last_idx(IMG_W));
  localparam logic [RW-1:0] LAST_R = RW'(last_idx(IMG_H));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      col <= (col == LAST_C) ? '0 : col + 1'b1;
      if (col == LAST_C) row <= (row == LAST_R) ? '0 : row + 1'b1;
    end
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: frame sequencing FSM and K x K window/stride decode for the line-buffered convolution
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output state_t                   state,
  output logic                     busy,
  output logic [$clog2(IMG_W)-1:0] col_cnt,
  output logic [$clog2(IMG_H)-1:0] row_cnt,
  output logic                     win_valid,
  output logic                     frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] FIRST_C = CW'(first_idx(K));
  localparam logic [RW-1:0] FIRST_R = RW'(first_idx(K));
  localparam logic [CW-1:0] SKIP_C  = CW'(skip_end(K));
  localparam logic [CW-1:0] LAST_C  = CW'(last_idx(IMG_W));
  localparam logic [RW-1:0] LAST_R  = RW'(last_idx(IMG_H));
  if (!stride_ok(STRIDE)) begin : g_bad_stride
    $error("conv_window_ctrl: STRIDE must be 1 or 2");
  end
  logic accept, geom, aligned, clr;
  assign accept  = in_valid && busy;
  assign clr     = (state == S_IDLE) && start;
  assign geom    = (row_cnt >= FIRST_R) && (col_cnt >= FIRST_C);
  // parity of (pos - (K-1)) reduces to comparing LSBs
  assign aligned = (STRIDE == 1) || ((row_cnt[0] == FIRST_R[0]) && (col_cnt[0] == FIRST_C[0]));
  conv_raster_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (accept),
    .col (col_cnt),
    .row (row_cnt)
  );
  // only SKIP/FILL cover non-window pixels, so the window flag needs no state gating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= accept && geom && aligned;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_FILL;
          busy  <= 1'b1;
        end
        S_FILL: if (accept && row_cnt == FIRST_R && col_cnt == FIRST_C) state <= S_COMPUTE;
        S_COMPUTE: if (accept && col_cnt == LAST_C) begin
          state      <= (row_cnt == LAST_R) ? S_DONE : S_SKIP;
          busy       <= (row_cnt != LAST_R);
          frame_done <= (row_cnt == LAST_R);
        end
        S_SKIP: if (accept && col_cnt == SKIP_C) state <= S_COMPUTE;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: randomized frames checked every cycle against a pixel-count reference model
module tb_conv_window_ctrl;
  import conv_pkg::*;
  localparam int W = 16, H = 16, K = 3;
  logic clk = 1'b0, rst, start, in_valid;
  state_t st1, st2;
  logic busy1, busy2, win1, win2, fd1, fd2;
  logic [3:0] col1, col2, row1, row2;
  int total = 0, bad = 0;

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .state(st1), .busy(busy1),
    .col_cnt(col1), .row_cnt(row1), .win_valid(win1), .frame_done(fd1));
  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .state(st2), .busy(busy2),
    .col_cnt(col2), .row_cnt(row2), .win_valid(win2), .frame_done(fd2));

  always #5 clk = ~clk;

  task automatic check(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask

  // reference model: a frame is just a count of accepted pixels
  bit m_act = 0, m_done = 0, m_w1 = 0, m_w2 = 0;
  int m_cnt = 0;

  function automatic bit win_at(input int n, input int s);
    int r, c;
    r = n / W;
    c = n % W;
    return r >= K - 1 && c >= K - 1 && ((r - (K - 1)) % s == 0) && ((c - (K - 1)) % s == 0);
  endfunction

  function automatic int exp_state();
    int r, c;
    if (m_done) return 4;
    if (!m_act) return 0;
    r = m_cnt / W;
    c = m_cnt % W;
    if (m_cnt <= (K - 1) * W + (K - 1)) return 1;
    if (r >= K && c <= K - 2) return 3;
    return 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 0; m_done <= 0; m_w1 <= 0; m_w2 <= 0; m_cnt <= 0;
    end else begin
      m_w1 <= 0;
      m_w2 <= 0;
      if (m_done) m_done <= 0;
      else if (!m_act) begin
        if (start) begin
          m_act <= 1;
          m_cnt <= 0;
        end
      end else if (in_valid) begin
        m_w1  <= win_at(m_cnt, 1);
        m_w2  <= win_at(m_cnt, 2);
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == W * H) begin
          m_act  <= 0;
          m_done <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("state1", int'(st1), exp_state());
    check("state2", int'(st2), exp_state());
    check("busy1", int'(busy1), int'(m_act));
    check("busy2", int'(busy2), int'(m_act));
    check("col1", int'(col1), m_cnt % W);
    check("col2", int'(col2), m_cnt % W);
    check("row1", int'(row1), (m_cnt / W) % H);
    check("row2", int'(row2), (m_cnt / W) % H);
    check("win_s1", int'(win1), int'(m_w1));
    check("win_s2", int'(win2), int'(m_w2));
    check("done1", int'(fd1), int'(m_done));
    check("done2", int'(fd2), int'(m_done));
  end

  task automatic run_frame(input int pct, input bit poke, output int w1, output int w2,
                           output int fd, output int first_win, output int st_pre,
                           output int st_win, output int fd_it, output int skip_px);
    int prev_st;
    w1 = 0; w2 = 0; fd = 0; first_win = 0; st_pre = 0; st_win = 0; fd_it = 0; skip_px = 0;
    prev_st = 0;
    @(posedge clk); #2;
    start = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); #2;
      start = poke && (i == 60);
      in_valid = $urandom_range(99) < pct;
      @(negedge clk);
      if (st1 == S_SKIP && in_valid) skip_px++;
      if (win1) begin
        w1++;
        if (first_win == 0) begin
          first_win = i;
          st_win = int'(st1);
          st_pre = prev_st;
        end
      end
      if (win2) w2++;
      if (fd1) begin
        fd++;
        fd_it = i;
        break;
      end
      prev_st = int'(st1);
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int w1, w2, fd, fw, sp, sw, fi, sk;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    #3;
    check("rst_state", int'(st1), 0);
    check("rst_busy", int'(busy1), 0);
    check("rst_col", int'(col1), 0);
    check("rst_row", int'(row1), 0);
    check("rst_win", int'(win1), 0);
    check("rst_done", int'(fd1), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
      in_valid = 1'b1;
    end
    run_frame(100, 0, w1, w2, fd, fw, sp, sw, fi, sk);
    check("full_wins_s1", w1, 196);
    check("full_wins_s2", w2, 49);
    check("full_done_cnt", fd, 1);
    check("first_win_cycle", fw, 36);
    check("state_pixel35", sp, 1);
    check("state_first_win", sw, 2);
    check("done_cycle", fi, 257);
    check("skip_pixels", sk, 26);
    repeat (3) begin
      @(posedge clk); #2;
      in_valid = 1'b1;
    end
    run_frame(50, 1, w1, w2, fd, fw, sp, sw, fi, sk);
    check("gap_wins_s1", w1, 196);
    check("gap_wins_s2", w2, 49);
    check("gap_done_cnt", fd, 1);
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    in_valid = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_col", int'(col1), 4);
    check("abort_row", int'(row1), 6);
    #2;
    rst = 1'b1;
    #1;
    check("abort_state", int'(st1), 0);
    check("abort_busy", int'(busy1), 0);
    check("abort_col0", int'(col1), 0);
    check("abort_row0", int'(row1), 0);
    check("abort_win", int'(win1), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    fd = 0;
    repeat (4) begin
      @(negedge clk);
      if (fd1) fd++;
    end
    check("abort_no_done", fd, 0);
    run_frame(100, 0, w1, w2, fd, fw, sp, sw, fi, sk);
    check("after_abort_wins", w1, 196);
    check("after_abort_done", fd, 1);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
